// File: rtl/gpio_bank_array_pkg.sv
// Shared definitions for the GPIO bank array: register offsets and APB FSM encoding.
package gpio_bank_array_pkg;

   localparam int unsigned REG_OUT  = 0;
   localparam int unsigned REG_OE   = 1;
   localparam int unsigned REG_PU   = 2;
   localparam int unsigned REG_PD   = 3;
   localparam int unsigned REG_IN   = 4;
   localparam int unsigned REG_IE   = 5;
   localparam int unsigned REG_POL  = 6;
   localparam int unsigned REG_STAT = 7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } apb_state_t;

endpackage

// File: rtl/gpio_bank_array_regs.sv
// One GPIO bank: control registers, input synchroniser and edge-interrupt status.
module gpio_bank_regs
   import gpio_bank_array_pkg::*;
#(
   parameter int unsigned PINS        = 8,
   parameter int unsigned PADDR_WIDTH = 3
) (
   input  logic                   pclk,
   input  logic                   presetn,
   input  logic                   i_wr,
   input  logic [PADDR_WIDTH-1:0] i_addr,
   input  logic [PINS-1:0]        i_wdata,
   input  logic [PINS-1:0]        i_y,
   output logic [PINS-1:0]        o_a,
   output logic [PINS-1:0]        o_oe,
   output logic [PINS-1:0]        o_pu,
   output logic [PINS-1:0]        o_pd,
   output logic [PINS-1:0]        o_stat,
   output logic [PINS-1:0]        o_rdata_c
);

   logic [PINS-1:0] r_out, r_oe, r_pu, r_pd, r_ie, r_pol, r_stat;
   logic [PINS-1:0] r_s1, r_s2, r_s3;
   logic [PINS-1:0] w_rise, w_fall, w_set, w_clr;

   assign w_rise = r_s2 & ~r_s3;
   assign w_fall = ~r_s2 & r_s3;
   assign w_set  = r_ie & ((r_pol & w_rise) | (~r_pol & w_fall));
   assign w_clr  = (i_wr && (i_addr == PADDR_WIDTH'(REG_STAT))) ? i_wdata : '0;

   // Register file, synchroniser chain and sticky status (set beats clear)
   always_ff @(posedge pclk) begin
      if (!presetn) begin
         r_out  <= '0;
         r_oe   <= '0;
         r_pu   <= '0;
         r_pd   <= '0;
         r_ie   <= '0;
         r_pol  <= '0;
         r_stat <= '0;
         r_s1   <= '0;
         r_s2   <= '0;
         r_s3   <= '0;
      end else begin
         r_s1   <= i_y;
         r_s2   <= r_s1;
         r_s3   <= r_s2;
         r_stat <= (r_stat & ~w_clr) | w_set;
         if (i_wr) begin
            case (i_addr)
               PADDR_WIDTH'(REG_OUT): r_out <= i_wdata;
               PADDR_WIDTH'(REG_OE):  r_oe  <= i_wdata;
               PADDR_WIDTH'(REG_PU):  r_pu  <= i_wdata;
               PADDR_WIDTH'(REG_PD):  r_pd  <= i_wdata;
               PADDR_WIDTH'(REG_IE):  r_ie  <= i_wdata;
               PADDR_WIDTH'(REG_POL): r_pol <= i_wdata;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      o_rdata_c = '0;
      case (i_addr)
         PADDR_WIDTH'(REG_OUT):  o_rdata_c = r_out;
         PADDR_WIDTH'(REG_OE):   o_rdata_c = r_oe;
         PADDR_WIDTH'(REG_PU):   o_rdata_c = r_pu;
         PADDR_WIDTH'(REG_PD):   o_rdata_c = r_pd;
         PADDR_WIDTH'(REG_IN):   o_rdata_c = r_s2;
         PADDR_WIDTH'(REG_IE):   o_rdata_c = r_ie;
         PADDR_WIDTH'(REG_POL):  o_rdata_c = r_pol;
         PADDR_WIDTH'(REG_STAT): o_rdata_c = r_stat;
         default:                o_rdata_c = '0;
      endcase
   end

   assign o_a    = r_out;
   assign o_oe   = r_oe;
   assign o_pu   = r_pu;
   assign o_pd   = r_pd & ~r_pu;
   assign o_stat = r_stat;

endmodule

// File: rtl/gpio_bank_array.sv
// APB front end for BANK_NUM GPIO banks: transfer FSM, select check, read mux and irq.
module gpio_bank_array
   import gpio_bank_array_pkg::*;
#(
   parameter  int unsigned BANK_NUM    = 2,
   parameter  int unsigned PINS        = 8,
   parameter  int unsigned PADDR_WIDTH = 3,
   localparam int unsigned NPIN        = BANK_NUM * PINS
) (
   input  logic                   pclk,
   input  logic                   presetn,
   input  logic [PADDR_WIDTH-1:0] paddr,
   input  logic [BANK_NUM-1:0]    psel,
   input  logic                   penable,
   input  logic                   pwrite,
   input  logic [PINS-1:0]        pwdata,
   output logic                   pready,
   output logic [PINS-1:0]        prdata,
   output logic                   pslverr,
   input  logic [NPIN-1:0]        gpio_y,
   output logic [NPIN-1:0]        gpio_a,
   output logic [NPIN-1:0]        gpio_oe,
   output logic [NPIN-1:0]        gpio_pu,
   output logic [NPIN-1:0]        gpio_pd,
   output logic                   irq
);

   apb_state_t r_state, w_state_nxt;
   logic       w_commit;
   logic       w_onehot, w_err;
   logic [BANK_NUM-1:0]           w_bank_wr;
   logic [BANK_NUM-1:0][PINS-1:0] w_bank_rdata;
   logic [PINS-1:0]               w_rdata;
   logic [NPIN-1:0]               w_stat_all;

   always_ff @(posedge pclk) begin
      if (!presetn) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Setup -> access -> one wait state; w_commit marks the edge entering DONE
   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if ((|psel) && !penable) w_state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (!(|psel)) begin
               w_state_nxt = ST_IDLE;
            end else if (penable) begin
               w_state_nxt = ST_DONE;
               w_commit    = 1'b1;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_onehot = (psel != '0) && ((psel & (psel - BANK_NUM'(1))) == '0);
   assign w_err    = !w_onehot || (pwrite && (paddr == PADDR_WIDTH'(REG_IN)));

   always_comb begin
      w_rdata = '0;
      for (int unsigned b = 0; b < BANK_NUM; b++) begin
         if (psel[b]) w_rdata = w_rdata | w_bank_rdata[b];
      end
   end

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         pready  <= 1'b0;
         pslverr <= 1'b0;
         prdata  <= '0;
         irq     <= 1'b0;
      end else begin
         pready  <= w_commit;
         pslverr <= w_commit && w_err;
         irq     <= |w_stat_all;
         if (w_commit) begin
            if (!w_onehot)    prdata <= '0;
            else if (!pwrite) prdata <= w_rdata;
         end
      end
   end

   for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
      assign w_bank_wr[b] = w_commit && pwrite && !w_err && psel[b];

      gpio_bank_regs #(
         .PINS        (PINS),
         .PADDR_WIDTH (PADDR_WIDTH)
      ) u_bank (
         .pclk      (pclk),
         .presetn   (presetn),
         .i_wr      (w_bank_wr[b]),
         .i_addr    (paddr),
         .i_wdata   (pwdata),
         .i_y       (gpio_y[b*PINS +: PINS]),
         .o_a       (gpio_a[b*PINS +: PINS]),
         .o_oe      (gpio_oe[b*PINS +: PINS]),
         .o_pu      (gpio_pu[b*PINS +: PINS]),
         .o_pd      (gpio_pd[b*PINS +: PINS]),
         .o_stat    (w_stat_all[b*PINS +: PINS]),
         .o_rdata_c (w_bank_rdata[b])
      );
   end

endmodule

// File: tb/tb_gpio_bank_array.sv
// Directed bench for gpio_bank_array with hand-computed expectations.
module tb_gpio_bank_array;

   logic        pclk = 1'b0;
   logic        presetn;
   logic [2:0]  paddr;
   logic [1:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [7:0]  pwdata;
   logic        pready;
   logic [7:0]  prdata;
   logic        pslverr;
   logic [15:0] gpio_y;
   logic [15:0] gpio_a, gpio_oe, gpio_pu, gpio_pd;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;

   gpio_bank_array dut (
      .pclk    (pclk),
      .presetn (presetn),
      .paddr   (paddr),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .pwdata  (pwdata),
      .pready  (pready),
      .prdata  (prdata),
      .pslverr (pslverr),
      .gpio_y  (gpio_y),
      .gpio_a  (gpio_a),
      .gpio_oe (gpio_oe),
      .gpio_pu (gpio_pu),
      .gpio_pd (gpio_pd),
      .irq     (irq)
   );

   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Full APB transfer; pready must be low in the access cycle and high in the third
   task automatic apb_xfer(input string tag, input logic [1:0] sel, input logic [2:0] addr,
                           input logic wr, input logic [7:0] wdata,
                           output logic [7:0] rdata, output logic err);
      @(posedge pclk); #1;
      psel = sel; paddr = addr; pwrite = wr; pwdata = wdata; penable = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      check({tag, ".pready_acc"}, pready, 1'b0);
      @(posedge pclk); #1;
      check({tag, ".pready"}, pready, 1'b1);
      rdata = prdata;
      err   = pslverr;
      @(posedge pclk); #1;
      psel = '0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_wr(input string tag, input logic [1:0] sel, input logic [2:0] addr,
                         input logic [7:0] wdata, input logic exp_err);
      logic [7:0] rd;
      logic       err;
      apb_xfer(tag, sel, addr, 1'b1, wdata, rd, err);
      check({tag, ".slverr"}, err, exp_err);
   endtask

   task automatic apb_rd(input string tag, input logic [1:0] sel, input logic [2:0] addr,
                         input logic [7:0] exp_data, input logic exp_err);
      logic [7:0] rd;
      logic       err;
      apb_xfer(tag, sel, addr, 1'b0, 8'h00, rd, err);
      check({tag, ".slverr"}, err, exp_err);
      check({tag, ".prdata"}, rd, exp_data);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      presetn = 1'b0; paddr = '0; psel = '0; penable = 1'b0;
      pwrite = 1'b0; pwdata = '0; gpio_y = '0;
      wait_cycles(3);
      check("rst.gpio_a",  gpio_a,  16'h0);
      check("rst.gpio_oe", gpio_oe, 16'h0);
      check("rst.gpio_pu", gpio_pu, 16'h0);
      check("rst.gpio_pd", gpio_pd, 16'h0);
      check("rst.irq",     irq,     1'b0);
      check("rst.pready",  pready,  1'b0);
      check("rst.pslverr", pslverr, 1'b0);
      check("rst.prdata",  prdata,  8'h00);
      presetn = 1'b1;

      // All registers of both banks read zero after reset
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < 8; a++)
            apb_rd($sformatf("rst_rd.b%0d.r%0d", b, a), 2'(1 << b), 3'(a), 8'h00, 1'b0);

      // Bank 1 output drive
      apb_wr("b1_oe", 2'b10, 3'd1, 8'hFF, 1'b0);
      apb_wr("b1_out", 2'b10, 3'd0, 8'hA5, 1'b0);
      check("b1.gpio_oe", gpio_oe, 16'hFF00);
      check("b1.gpio_a",  gpio_a,  16'hA500);
      apb_rd("b1_out_rd", 2'b10, 3'd0, 8'hA5, 1'b0);

      // Bank 0 pulls; pull-up wins over pull-down
      apb_wr("b0_pu", 2'b01, 3'd2, 8'h0F, 1'b0);
      apb_wr("b0_pd", 2'b01, 3'd3, 8'hFF, 1'b0);
      check("b0.gpio_pu", gpio_pu, 16'h000F);
      check("b0.gpio_pd", gpio_pd, 16'h00F0);
      apb_rd("b0_pd_rd", 2'b01, 3'd3, 8'hFF, 1'b0);

      // Rising-edge interrupt on pin 0
      apb_wr("b0_ie",  2'b01, 3'd5, 8'h01, 1'b0);
      apb_wr("b0_pol", 2'b01, 3'd6, 8'h01, 1'b0);
      check("pre_edge.irq", irq, 1'b0);
      gpio_y[0] = 1'b1;
      wait_cycles(4);
      check("rise.irq", irq, 1'b1);
      apb_rd("rise_stat", 2'b01, 3'd7, 8'h01, 1'b0);
      apb_rd("in_rd", 2'b01, 3'd4, 8'h01, 1'b0);
      apb_wr("w1c", 2'b01, 3'd7, 8'h01, 1'b0);
      check("w1c.irq", irq, 1'b0);
      apb_rd("w1c_stat", 2'b01, 3'd7, 8'h00, 1'b0);
      gpio_y[0] = 1'b0;
      wait_cycles(5);
      check("fall.irq", irq, 1'b0);
      apb_rd("fall_stat", 2'b01, 3'd7, 8'h00, 1'b0);

      // Error responses: non-one-hot select and write to IN
      apb_rd("prime_rd", 2'b10, 3'd0, 8'hA5, 1'b0);
      apb_wr("bad_sel", 2'b11, 3'd0, 8'hFF, 1'b1);
      check("bad_sel.prdata", prdata, 8'h00);
      check("bad_sel.gpio_a", gpio_a, 16'hA500);
      apb_wr("wr_in", 2'b01, 3'd4, 8'hFF, 1'b1);
      apb_rd("in_after_wr", 2'b01, 3'd4, 8'h00, 1'b0);

      // psel dropped during access: transfer abandoned, nothing written
      @(posedge pclk); #1;
      psel = 2'b01; paddr = 3'd0; pwrite = 1'b1; pwdata = 8'h33; penable = 1'b0;
      @(posedge pclk); #1;
      psel = '0; pwrite = 1'b0;
      @(posedge pclk); #1;
      check("abort.pready", pready, 1'b0);
      apb_rd("abort_out", 2'b01, 3'd0, 8'h00, 1'b0);

      // W1C coinciding with a new rising edge: set wins
      gpio_y[0] = 1'b1;
      wait_cycles(5);
      apb_rd("pre_coll_stat", 2'b01, 3'd7, 8'h01, 1'b0);
      gpio_y[0] = 1'b0;
      wait_cycles(5);
      @(posedge pclk); #1;
      gpio_y[0] = 1'b1;
      apb_wr("coll_w1c", 2'b01, 3'd7, 8'h01, 1'b0);
      apb_rd("coll_stat", 2'b01, 3'd7, 8'h01, 1'b0);
      check("coll.irq", irq, 1'b1);

      // IE=0 keeps existing status until cleared
      apb_wr("ie_off", 2'b01, 3'd5, 8'h00, 1'b0);
      apb_rd("ie_off_stat", 2'b01, 3'd7, 8'h01, 1'b0);
      apb_wr("final_w1c", 2'b01, 3'd7, 8'h01, 1'b0);
      apb_rd("final_stat", 2'b01, 3'd7, 8'h00, 1'b0);
      check("final.irq", irq, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
